// File: rtl/motor_step_gen.sv
// motor_step_gen: turns a latched move command into a timed STEP/DIR pulse
// train for an external stepper driver.
//
// Optional feature macro: MOTOR_STEP_IRQ_EN
//   defined     -> an 'irq' output pulses for one cycle when a move finishes
//                  normally, is aborted, or is a zero-step command.
//   not defined -> no 'irq' port; completion is seen via busy and steps_done.
//
// Command handshake: a command transfers on a rising ACLK edge where both
// cmd_valid and cmd_ready are high. cmd_ready is the inverse of busy, so a
// command offered during a move waits, with cmd_valid held, until the
// first IDLE cycle.
//
// Phase lengths are counted by a PER_W-bit down-counter, which is also used
// for the DIR setup delay. DIR_SETUP must therefore fit in PER_W bits.
module motor_step_gen #(
    parameter int CNT_W     = 32,
    parameter int PER_W     = 16,
    parameter int DIR_SETUP = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [PER_W-1:0] cmd_high,
    input  logic             abort,
    output logic             step_out,
    output logic             dir_out,
    output logic             busy,
    output logic [CNT_W-1:0] steps_done
`ifdef MOTOR_STEP_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    // The setup counter is loaded with DIR_SETUP-1 so that exactly DIR_SETUP
    // cycles pass between acceptance and the first STEP rise.
    localparam bit               HAS_SETUP  = (DIR_SETUP > 0);
    localparam logic [PER_W-1:0] SETUP_LOAD = HAS_SETUP ? PER_W'(DIR_SETUP - 1) : '0;
    localparam logic [PER_W-1:0] PER_MIN    = PER_W'(2);
    localparam logic [PER_W-1:0] PH_ONE     = PER_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;       // cycles left in the current phase, minus one
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] done_q, done_d;     // completed pulses of the current/last move
    logic [CNT_W-1:0] steps_q, steps_d;   // requested pulse count of the current move
    logic [PER_W-1:0] high_q, high_d;     // effective high time
    logic [PER_W-1:0] low_q, low_d;       // effective low time (period - high)

    logic [PER_W-1:0] per_eff;
    logic [PER_W-1:0] high_eff;
    logic             accept;

    // Clamp the requested timing so every pulse has at least one high and
    // one low cycle.
    always_comb begin
        per_eff = (cmd_period < PER_MIN) ? PER_MIN : cmd_period;
        if (cmd_high == '0) begin
            high_eff = PH_ONE;
        end else if (cmd_high >= per_eff) begin
            high_eff = per_eff - PH_ONE;
        end else begin
            high_eff = cmd_high;
        end
    end

    assign accept = cmd_valid && cmd_ready;

    // State register: FSM state plus the phase counter and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Command register: move parameters captured at acceptance.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            steps_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
        end else begin
            steps_q <= steps_d;
            high_q  <= high_d;
            low_q   <= low_d;
        end
    end

    // Next-state logic: sequences SETUP -> (HIGH -> LOW)* -> IDLE; abort wins
    // over every phase transition while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        dir_d   = dir_q;
        done_d  = done_q;
        steps_d = steps_q;
        high_d  = high_q;
        low_d   = low_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d   = cmd_dir;
                    done_d  = '0;
                    steps_d = cmd_steps;
                    high_d  = high_eff;
                    low_d   = per_eff - high_eff;
                    if (cmd_steps != '0) begin
                        if (HAS_SETUP) begin
                            state_d = ST_SETUP;
                            cnt_d   = SETUP_LOAD;
                            step_d  = 1'b0;
                        end else begin
                            state_d = ST_HIGH;
                            cnt_d   = high_eff - PH_ONE;
                            step_d  = 1'b1;
                        end
                    end
                end
            end

            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    step_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = high_q - PH_ONE;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end

            ST_HIGH: begin
                if (abort) begin
                    // The partial pulse is dropped and not counted.
                    state_d = ST_IDLE;
                    step_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = low_q - PH_ONE;
                    step_d  = 1'b0;
                    done_d  = done_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end

            ST_LOW: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    step_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    // Equality compare, so an all-ones step count never wraps.
                    if (done_q == steps_q) begin
                        state_d = ST_IDLE;
                        step_d  = 1'b0;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = high_q - PH_ONE;
                        step_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PH_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = 1'b0;
            end
        endcase
    end

    // Output logic: busy is any non-IDLE state; pulse outputs come straight
    // from registers so the driver sees glitch-free edges.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        cmd_ready  = !busy;
        step_out   = step_q;
        dir_out    = dir_q;
        steps_done = done_q;
    end

`ifdef MOTOR_STEP_IRQ_EN
    logic irq_d, irq_q;

    // A move ends when the FSM returns to IDLE (completion or abort) or when
    // a zero-step command is accepted.
    always_comb begin
        irq_d = ((state_q != ST_IDLE) && (state_d == ST_IDLE)) ||
                (accept && (cmd_steps == '0));
    end

    // Register the completion pulse so it lines up with the busy fall.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_motor_step_gen.sv
// Testbench for motor_step_gen (DIR_SETUP=4, CNT_W=32, PER_W=16).
// Table of move commands with hand-computed pulse shapes, followed by
// hand-written sequences for abort, back-to-back commands and async reset.
module tb_motor_step_gen;

    localparam int CNT_W     = 32;
    localparam int PER_W     = 16;
    localparam int DIR_SETUP = 4;

    // ---------------- clock / reset ----------------
    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;
    logic [PER_W-1:0] cmd_high;
    logic             abort;
    logic             step_out;
    logic             dir_out;
    logic             busy;
    logic [CNT_W-1:0] steps_done;
`ifdef MOTOR_STEP_IRQ_EN
    logic             irq;
`endif

    motor_step_gen #(
        .CNT_W    (CNT_W),
        .PER_W    (PER_W),
        .DIR_SETUP(DIR_SETUP)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .cmd_high  (cmd_high),
        .abort     (abort),
        .step_out  (step_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .steps_done(steps_done)
`ifdef MOTOR_STEP_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input logic dir, input logic [CNT_W-1:0] steps,
                             input logic [PER_W-1:0] period, input logic [PER_W-1:0] high);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = period;
        cmd_high   = high;
    endtask

    // Waveform statistics collected by capture()
    int c_first, c_pulses, c_hmin, c_hmax, c_lmin, c_lmax, c_busy, c_irq;

    task automatic rec_high(input int n);
        if (n < c_hmin) c_hmin = n;
        if (n > c_hmax) c_hmax = n;
    endtask

    task automatic rec_low(input int n);
        if (n < c_lmin) c_lmin = n;
        if (n > c_lmax) c_lmax = n;
    endtask

    // Sample ncyc consecutive negedges, starting at the current one (k=0 is
    // the cycle right after the accepting edge). Low runs count only the
    // cycles where busy is still high.
    task automatic capture(input int ncyc);
        logic ps;
        logic s, b;
        int   hrun, lrun;
        bit   in_low;
        ps = 1'b0; hrun = 0; lrun = 0; in_low = 0;
        c_first = -1; c_pulses = 0; c_busy = 0; c_irq = 0;
        c_hmin = 1 << 30; c_hmax = 0; c_lmin = 1 << 30; c_lmax = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge ACLK);
            s = step_out;
            b = busy;
            if (b) c_busy++;
`ifdef MOTOR_STEP_IRQ_EN
            if (irq) c_irq++;
`endif
            if (s) begin
                if (!ps) begin
                    c_pulses++;
                    if (c_first < 0) c_first = k;
                    if (in_low) begin
                        rec_low(lrun);
                        in_low = 0;
                    end
                    hrun = 0;
                end
                hrun++;
            end else if (ps) begin
                rec_high(hrun);
                in_low = b;
                lrun   = b ? 1 : 0;
            end else if (in_low) begin
                if (b) lrun++;
                else begin
                    rec_low(lrun);
                    in_low = 0;
                end
            end
            ps = s;
        end
        if (in_low) rec_low(lrun);
        if (ps) rec_high(hrun);
        if (c_hmin == (1 << 30)) c_hmin = 0;
        if (c_lmin == (1 << 30)) c_lmin = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             dir;
        logic [CNT_W-1:0] steps;
        logic [PER_W-1:0] period;
        logic [PER_W-1:0] high;
        int               e_first;
        int               e_pulses;
        int               e_high;
        int               e_low;
        int               e_busy;
        int               e_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int ready_bad;

        // dir, steps, period, high | first rise, pulses, high, low, busy, done
        vecs[0] = '{1'b1, 32'd3, 16'd10, 16'd4,  4, 3, 4, 6, 34, 3}; // normal move
        vecs[1] = '{1'b1, 32'd0, 16'd10, 16'd4, -1, 0, 0, 0,  0, 0}; // zero steps
        vecs[2] = '{1'b0, 32'd4, 16'd1,  16'd0,  4, 4, 1, 1, 12, 4}; // period/high clamp
        vecs[3] = '{1'b1, 32'd2, 16'd5,  16'd9,  4, 2, 4, 1, 14, 2}; // high >= period
        vecs[4] = '{1'b0, 32'd2, 16'd3,  16'd3,  4, 2, 2, 1, 10, 2}; // high == period
        vecs[5] = '{1'b1, 32'd1, 16'd6,  16'd0,  4, 1, 1, 5, 10, 1}; // high 0 -> 1
        vecs[6] = '{1'b0, 32'd3, 16'd0,  16'd2,  4, 3, 1, 1, 10, 3}; // period 0 -> 2

        ARESETN    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        cmd_high   = '0;
        abort      = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge ACLK);
        chk("rst_step", 32'(step_out), 32'd0);
        chk("rst_dir", 32'(dir_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", steps_done, 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
`ifdef MOTOR_STEP_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
        ARESETN = 1'b1;
        @(negedge ACLK);

        // ---- table-driven moves ----
        for (int i = 0; i < 7; i++) begin
            drive_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].high);
            @(negedge ACLK);
            cmd_valid = 1'b0;
            chk($sformatf("v%0d_dir_at_accept", i), 32'(dir_out), 32'(vecs[i].dir));
            capture(vecs[i].e_busy + 4);
            chk($sformatf("v%0d_first_rise", i), c_first, vecs[i].e_first);
            chk($sformatf("v%0d_pulses", i), c_pulses, vecs[i].e_pulses);
            chk($sformatf("v%0d_high_min", i), c_hmin, vecs[i].e_high);
            chk($sformatf("v%0d_high_max", i), c_hmax, vecs[i].e_high);
            chk($sformatf("v%0d_low_min", i), c_lmin, vecs[i].e_low);
            chk($sformatf("v%0d_low_max", i), c_lmax, vecs[i].e_low);
            chk($sformatf("v%0d_busy_cycles", i), c_busy, vecs[i].e_busy);
            chk($sformatf("v%0d_steps_done", i), steps_done, 32'(vecs[i].e_done));
            chk($sformatf("v%0d_dir_hold", i), 32'(dir_out), 32'(vecs[i].dir));
            chk($sformatf("v%0d_ready_end", i), 32'(cmd_ready), 32'd1);
`ifdef MOTOR_STEP_IRQ_EN
            chk($sformatf("v%0d_irq_count", i), c_irq, 1);
`endif
        end

        // ---- abort on the 2nd cycle of pulse 3 (pulse 3 high at k=20..23) ----
        drive_cmd(1'b0, 32'd10, 16'd8, 16'd4);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        repeat (21) @(negedge ACLK);
        chk("abort_step_before", 32'(step_out), 32'd1);
        chk("abort_done_before", steps_done, 32'd2);
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("abort_step", 32'(step_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", steps_done, 32'd2);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
`ifdef MOTOR_STEP_IRQ_EN
        chk("abort_irq", 32'(irq), 32'd1);
`endif
        @(negedge ACLK);
        chk("abort_step_after", 32'(step_out), 32'd0);
`ifdef MOTOR_STEP_IRQ_EN
        chk("abort_irq_one_cycle", 32'(irq), 32'd0);
`endif

        // ---- abort while idle is ignored ----
        abort = 1'b1;
        @(negedge ACLK);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_ready", 32'(cmd_ready), 32'd1);
        chk("idle_abort_done", steps_done, 32'd2);
`ifdef MOTOR_STEP_IRQ_EN
        chk("idle_abort_irq", 32'(irq), 32'd0);
`endif

        // ---- back-to-back: second command held valid during first move ----
        // first move: 2 steps, period 4 -> busy k=0..11
        drive_cmd(1'b1, 32'd2, 16'd4, 16'd2);
        @(negedge ACLK);
        drive_cmd(1'b0, 32'd2, 16'd4, 16'd2);
        ready_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge ACLK);
            if (cmd_ready !== 1'b0) ready_bad++;
        end
        chk("b2b_ready_low_while_busy", ready_bad, 0);
        @(negedge ACLK);
        chk("b2b_busy_fall", 32'(busy), 32'd0);
        chk("b2b_ready_rise", 32'(cmd_ready), 32'd1);
        chk("b2b_dir_first", 32'(dir_out), 32'd1);
        chk("b2b_done_first", steps_done, 32'd2);
`ifdef MOTOR_STEP_IRQ_EN
        chk("b2b_irq_first", 32'(irq), 32'd1);
`endif
        @(negedge ACLK);
        cmd_valid = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        chk("b2b_accept_dir", 32'(dir_out), 32'd0);
        chk("b2b_accept_done", steps_done, 32'd0);
        chk("b2b_accept_ready", 32'(cmd_ready), 32'd0);
        repeat (12) @(negedge ACLK);
        chk("b2b_second_end_busy", 32'(busy), 32'd0);
        chk("b2b_second_done", steps_done, 32'd2);
        chk("b2b_second_dir", 32'(dir_out), 32'd0);

        // ---- asynchronous reset during pulse 2 high (k=14..19) ----
        drive_cmd(1'b1, 32'd5, 16'd10, 16'd6);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        repeat (15) @(negedge ACLK);
        chk("rmid_step_before", 32'(step_out), 32'd1);
        chk("rmid_done_before", steps_done, 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("rmid_step", 32'(step_out), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_done", steps_done, 32'd0);
        chk("rmid_dir", 32'(dir_out), 32'd0);
        chk("rmid_ready", 32'(cmd_ready), 32'd1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rmid_after_busy", 32'(busy), 32'd0);
        chk("rmid_after_ready", 32'(cmd_ready), 32'd1);
        chk("rmid_after_step", 32'(step_out), 32'd0);

        // ---- final report ----
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
